// File: rtl/mips_md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: FSM states,
// mfhi/mflo read-select codes and default operation latencies.
package mips_md_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10
  } md_state_t;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_HI  = 2'b01;
  localparam logic [1:0] SEL_LO  = 2'b10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/md_datapath.sv
// Combinational arithmetic for md_unit: 64-bit product and 32-bit
// quotient/remainder, signed or unsigned, plus a divide-by-zero flag.
module md_datapath (
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic [63:0] ext_a, ext_b;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, divisor, uq, ur;

  // Product: operands extended to 64 bits; the low 64 bits of the product are
  // correct for both two's complement and unsigned interpretations.
  always_comb begin
    ext_a = sign ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b = sign ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = ext_a * ext_b;
  end

  // Division on magnitudes, signs restored afterwards: quotient truncates
  // toward zero, remainder follows the dividend. 0x80000000 / -1 wraps back to
  // 0x80000000 with remainder 0. A zero divisor is replaced by 1 only to keep the
  // divider well defined; the result is discarded via div_zero.
  always_comb begin
    neg_a    = sign & a[31];
    neg_b    = sign & b[31];
    mag_a    = neg_a ? (32'd0 - a) : a;
    mag_b    = neg_b ? (32'd0 - b) : b;
    div_zero = (b == 32'd0);
    divisor  = div_zero ? 32'd1 : mag_b;
    uq       = mag_a / divisor;
    ur       = mag_a % divisor;
    quot     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem      = neg_a ? (32'd0 - ur) : ur;
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit. Owns HI/LO, runs mult/multu/div/divu as a
// multi-cycle operation on latched operands, serves mfhi/mflo reads and
// raises the decode-stage stall while an MD-using instruction waits in D.
//
//  state   | meaning
//  MD_IDLE | no operation in flight; accepts start or mthi/mtlo
//  MD_MUL  | multiply in flight, counter counting down to commit
//  MD_DIV  | divide in flight, counter counting down to commit
module md_unit
  import mips_md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        InterruptRequest,
  input  logic        StartE,
  input  logic        MDE,
  input  logic        MDSignE,
  input  logic        HLWriteE,
  input  logic        HLSelE,
  input  logic [1:0]  ALUOutESelectE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        MDUseD,
  output logic [31:0] MDOutE,
  output logic        Busy,
  output logic        MulFlushE,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       op_a, op_b;
  logic              op_sign;
  logic [31:0]       hi_q, lo_q;
  logic              busy_q;

  logic [63:0]       prod;
  logic [31:0]       quot, rem;
  logic              div_zero;
  logic              start_ok, hl_ok;

  md_datapath u_dp (
    .sign     (op_sign),
    .a        (op_a),
    .b        (op_b),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  // Interrupt cancels the E-stage instruction; start takes priority over an
  // (illegal) simultaneous mthi/mtlo, and neither is honoured while busy.
  always_comb begin
    start_ok = StartE & ~InterruptRequest & (state == MD_IDLE);
    hl_ok    = HLWriteE & ~StartE & ~InterruptRequest & (state == MD_IDLE);
  end

  // Sequencer: latch operands at start, count down, commit HI/LO on the last busy cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_sign <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start_ok) begin
            state   <= MDE ? MD_DIV : MD_MUL;
            cnt     <= MDE ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            op_a    <= SrcAE;
            op_b    <= SrcBE;
            op_sign <= MDSignE;
            busy_q  <= 1'b1;
          end else if (hl_ok) begin
            if (HLSelE) hi_q <= SrcAE;
            else        lo_q <= SrcAE;
          end
        end
        MD_MUL: begin
          if (cnt == CNT_W'(1)) begin
            hi_q   <= prod[63:32];
            lo_q   <= prod[31:0];
            state  <= MD_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        MD_DIV: begin
          if (cnt == CNT_W'(1)) begin
            if (!div_zero) begin
              hi_q <= rem;
              lo_q <= quot;
            end
            state  <= MD_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state  <= MD_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Read mux and hazard request; MDOutE shows committed HI/LO only.
  always_comb begin
    case (ALUOutESelectE)
      SEL_HI:  MDOutE = hi_q;
      SEL_LO:  MDOutE = lo_q;
      default: MDOutE = 32'd0;
    endcase
    MulFlushE = MDUseD & (StartE | busy_q);
    Busy      = busy_q;
    HI        = hi_q;
    LO        = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  localparam int N_MUL = 5;
  localparam int N_DIV = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        InterruptRequest, StartE, MDE, MDSignE, HLWriteE, HLSelE, MDUseD;
  logic [1:0]  ALUOutESelectE;
  logic [31:0] SrcAE, SrcBE;
  logic [31:0] MDOutE, HI, LO;
  logic        Busy, MulFlushE;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;

  md_unit dut (
    .clk(clk), .reset(reset), .InterruptRequest(InterruptRequest), .StartE(StartE),
    .MDE(MDE), .MDSignE(MDSignE), .HLWriteE(HLWriteE), .HLSelE(HLSelE),
    .ALUOutESelectE(ALUOutESelectE), .SrcAE(SrcAE), .SrcBE(SrcBE), .MDUseD(MDUseD),
    .MDOutE(MDOutE), .Busy(Busy), .MulFlushE(MulFlushE), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // The hazard unit never issues start/mthi/mtlo while the unit is busy.
  always @(negedge clk) begin
    if (reset && Busy && (StartE || HLWriteE)) begin
      errors++;
      $display("FAIL busy_issue: StartE=%0b HLWriteE=%0b while Busy", StartE, HLWriteE);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural result of one mult/div from plain 64-bit arithmetic.
  task automatic model_op(input bit md, input bit sign, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] pv;
    sa = sign ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sign ? longint'($signed(b)) : longint'({32'd0, b});
    if (!md) begin
      p  = sa * sb;
      pv = p;
      ref_hi = pv[63:32];
      ref_lo = pv[31:0];
    end else if (b != 32'd0) begin
      q = sa / sb;
      r = sa % sb;
      pv = q;
      ref_lo = pv[31:0];
      pv = r;
      ref_hi = pv[31:0];
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    InterruptRequest = 0; StartE = 0; MDE = 0; MDSignE = 0; HLWriteE = 0; HLSelE = 0;
    MDUseD = 1; ALUOutESelectE = 2'b01; SrcAE = '1; SrcBE = '1;
    #2;
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL reset_hilo: HI=%h LO=%h want 0", HI, LO); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (MulFlushE !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", MulFlushE); end
    checks++; if (MDOutE !== 32'd0) begin errors++; $display("FAIL reset_mdout: got %h want 0", MDOutE); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    MDUseD = 0; ALUOutESelectE = 2'b00;
    tick;
  endtask

  task automatic hl_write(input bit sel_hi, input logic [31:0] val, input bit irq);
    HLWriteE = 1; HLSelE = sel_hi; SrcAE = val; InterruptRequest = irq;
    tick;
    HLWriteE = 0; InterruptRequest = 0;
    if (!irq) begin
      if (sel_hi) ref_hi = val; else ref_lo = val;
    end
    #1;
    checks++; if (HI !== ref_hi || LO !== ref_lo) begin
      errors++; $display("FAIL hl_write: HI=%h LO=%h want HI=%h LO=%h", HI, LO, ref_hi, ref_lo);
    end
  endtask

  task automatic run_op(input bit md, input bit sign, input logic [31:0] a, input logic [31:0] b,
                        input bit use_d, input bit irq_mid);
    int n;
    logic [31:0] old_lo;
    n = md ? N_DIV : N_MUL;
    old_lo = ref_lo;
    model_op(md, sign, a, b);
    StartE = 1; MDE = md; MDSignE = sign; SrcAE = a; SrcBE = b; MDUseD = use_d;
    ALUOutESelectE = 2'b10;
    #1;
    checks++; if (MulFlushE !== use_d) begin errors++; $display("FAIL start_flush: got %b want %b", MulFlushE, use_d); end
    tick;
    StartE = 0; SrcAE = $urandom; SrcBE = $urandom;
    for (int i = 0; i < n; i++) begin
      InterruptRequest = irq_mid && (i == 1);
      #1;
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL busy_cycle%0d: got %b want 1", i, Busy); end
      checks++; if (MulFlushE !== use_d) begin errors++; $display("FAIL busy_flush%0d: got %b want %b", i, MulFlushE, use_d); end
      checks++; if (MDOutE !== old_lo) begin errors++; $display("FAIL busy_mdout%0d: got %h want %h", i, MDOutE, old_lo); end
      tick;
    end
    InterruptRequest = 0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL done_busy: got %b want 0", Busy); end
    checks++; if (MulFlushE !== 1'b0) begin errors++; $display("FAIL done_flush: got %b want 0", MulFlushE); end
    checks++; if (HI !== ref_hi || LO !== ref_lo) begin
      errors++; $display("FAIL result md=%0b s=%0b a=%h b=%h: HI=%h LO=%h want HI=%h LO=%h",
                         md, sign, a, b, HI, LO, ref_hi, ref_lo);
    end
    checks++; if (MDOutE !== ref_lo) begin errors++; $display("FAIL mflo: got %h want %h", MDOutE, ref_lo); end
    ALUOutESelectE = 2'b01;
    #1;
    checks++; if (MDOutE !== ref_hi) begin errors++; $display("FAIL mfhi: got %h want %h", MDOutE, ref_hi); end
    ALUOutESelectE = 2'b00;
    #1;
    checks++; if (MDOutE !== 32'd0) begin errors++; $display("FAIL mdout_alu: got %h want 0", MDOutE); end
    MDUseD = 0;
  endtask

  task automatic test_mult;
    run_op(0, 1, 32'hFFFF_FFFE, 32'd3, 0, 0);
    checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_fixed: HI=%h LO=%h want FFFFFFFF FFFFFFFA", HI, LO);
    end
    run_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
  endtask

  task automatic test_div;
    run_op(1, 0, 32'd100, 32'd7, 0, 0);
    checks++; if (LO !== 32'd14 || HI !== 32'd2) begin errors++; $display("FAIL divu_fixed: HI=%h LO=%h want 2 14", HI, LO); end
    run_op(1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    checks++; if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_neg: HI=%h LO=%h want FFFFFFFF FFFFFFFD", HI, LO);
    end
  endtask

  task automatic test_div_corner;
    hl_write(1, 32'h11, 0);
    hl_write(0, 32'h22, 0);
    run_op(1, 1, 32'd1234, 32'd0, 0, 0);
    checks++; if (HI !== 32'h11 || LO !== 32'h22) begin errors++; $display("FAIL div_zero: HI=%h LO=%h want 11 22", HI, LO); end
    run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    checks++; if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
      errors++; $display("FAIL div_ovf: HI=%h LO=%h want 0 80000000", HI, LO);
    end
  endtask

  task automatic test_interrupt;
    StartE = 1; MDE = 0; MDSignE = 1; SrcAE = 32'd9; SrcBE = 32'd9; InterruptRequest = 1;
    tick;
    StartE = 0; InterruptRequest = 0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL irq_start: Busy=%b want 0", Busy); end
    tick;
    checks++; if (HI !== ref_hi || LO !== ref_lo) begin
      errors++; $display("FAIL irq_hilo: HI=%h LO=%h want %h %h", HI, LO, ref_hi, ref_lo);
    end
    hl_write(1, 32'hABCD, 1);
    hl_write(0, 32'h5A5A_0001, 0);
    run_op(0, 1, 32'd7, 32'hFFFF_FFF0, 0, 1);
  endtask

  task automatic test_flush;
    run_op(0, 0, 32'd123456, 32'd654321, 1, 0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 14; k++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom_range(1, 300) : $urandom);
      if ($urandom_range(0, 3) == 0) hl_write($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) == 0);
      run_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, b,
             $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
    end
  endtask

  task automatic test_reset_mid;
    hl_write(1, 32'hDEAD_BEEF, 0);
    StartE = 1; MDE = 0; MDSignE = 0; SrcAE = 32'd3; SrcBE = 32'd5;
    tick;
    StartE = 0;
    tick;
    tick;
    reset = 1'b0;
    ref_hi = 32'd0; ref_lo = 32'd0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", Busy); end
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL rst_mid_hilo: HI=%h LO=%h want 0", HI, LO); end
    tick;
    reset = 1'b1;
    repeat (8) tick;
    checks++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL rst_no_commit: Busy=%b HI=%h LO=%h want 0", Busy, HI, LO);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_corner;
    test_interrupt;
    test_flush;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
